// File: rtl/display_scan_driver_if.sv
// Scan driver bundle: enable and returned mux code in, phase select and
// active-low digit drive out.
interface display_scan_driver_if;
  logic       Enable;
  logic [3:0] Code;
  logic [1:0] Phase;
  logic       Tick;
  logic [6:0] Seg;
  logic [3:0] Anode;
  logic       Err;

  modport master (
    output Enable, Code,
    input  Phase, Tick, Seg, Anode, Err
  );

  modport slave (
    input  Enable, Code,
    output Phase, Tick, Seg, Anode, Err
  );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexed 4-digit scan: prescaled phase select, anti-ghost blanking,
// 7-segment decode. Digit lights BLANK_CYCLES enabled cycles after a phase change.
module display_scan_driver #(
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  display_scan_driver_if.slave bus
);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                 state_q;
  logic [DIV_WIDTH-1:0]   cnt_q;
  logic [DIV_WIDTH-1:0]   bcnt_q;
  logic [1:0]             phase_q;
  logic                   tick_q;
  logic [6:0]             seg_q;
  logic [3:0]             anode_q;
  logic                   err_q;

  logic [6:0]             seg_d;
  logic                   bad_d;

  // Active-low gfedcba; codes 1100..1111 blank the digit and flag an error
  always_comb begin
    seg_d = 7'b1111111;
    bad_d = 1'b0;
    case (bus.Code)
      4'h0:    seg_d = 7'b1000000;
      4'h1:    seg_d = 7'b1111001;
      4'h2:    seg_d = 7'b0100100;
      4'h3:    seg_d = 7'b0110000;
      4'h4:    seg_d = 7'b0011001;
      4'h5:    seg_d = 7'b0010010;
      4'h6:    seg_d = 7'b0000010;
      4'h7:    seg_d = 7'b1111000;
      4'h8:    seg_d = 7'b0000000;
      4'h9:    seg_d = 7'b0010000;
      4'hA:    seg_d = 7'b1000001;
      4'hB:    seg_d = 7'b0100011;
      default: bad_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 2'b00;
      tick_q  <= 1'b0;
      seg_q   <= 7'b1111111;
      anode_q <= 4'b1111;
      err_q   <= 1'b0;
    end else if (!bus.Enable) begin
      // Dark and frozen; re-enable replays a full blank for the held phase
      state_q <= BLANK;
      bcnt_q  <= '0;
      tick_q  <= 1'b0;
      anode_q <= 4'b1111;
    end else begin
      tick_q <= 1'b0;
      if (cnt_q == DIV_WIDTH'(DIV_MAX)) begin
        cnt_q   <= '0;
        phase_q <= phase_q + 2'd1;
        tick_q  <= 1'b1;
        state_q <= BLANK;
        bcnt_q  <= '0;
        anode_q <= 4'b1111;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        case (state_q)
          BLANK: begin
            if (bcnt_q == DIV_WIDTH'(BLANK_CYCLES - 1)) begin
              seg_q   <= seg_d;
              err_q   <= err_q | bad_d;
              anode_q <= ~(4'b0001 << phase_q);
              state_q <= SHOW;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
          SHOW: ;
          default: state_q <= BLANK;
        endcase
      end
    end
  end

  assign bus.Phase = phase_q;
  assign bus.Tick  = tick_q;
  assign bus.Seg   = seg_q;
  assign bus.Anode = anode_q;
  assign bus.Err   = err_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with DIV_MAX=9, BLANK_CYCLES=2.
module tb_display_scan_driver;
  logic Clock;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  display_scan_driver_if bus ();

  display_scan_driver #(
    .DIV_WIDTH   (4),
    .DIV_MAX     (9),
    .BLANK_CYCLES(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int         cyc;
    logic [1:0] ph;
    logic       tk;
    logic [3:0] an;
    logic [6:0] sg;
    logic       er;
  } vec_t;

  vec_t       vecs [19];
  logic [3:0] codes [11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ph, input logic tk,
                         input logic [3:0] an, input logic [6:0] sg, input logic er);
    chk({tag, ".phase"}, 16'(bus.Phase), 16'(ph));
    chk({tag, ".tick"},  16'(bus.Tick),  16'(tk));
    chk({tag, ".anode"}, 16'(bus.Anode), 16'(an));
    chk({tag, ".seg"},   16'(bus.Seg),   16'(sg));
    chk({tag, ".err"},   16'(bus.Err),   16'(er));
  endtask

  initial begin
    int ticks;
    vecs[0]  = '{0,   2'd0, 1'b0, 4'hF, 7'h7F, 1'b0};
    vecs[1]  = '{1,   2'd0, 1'b0, 4'hF, 7'h7F, 1'b0};
    vecs[2]  = '{2,   2'd0, 1'b0, 4'hE, 7'h30, 1'b0};
    vecs[3]  = '{9,   2'd0, 1'b0, 4'hE, 7'h30, 1'b0};
    vecs[4]  = '{10,  2'd1, 1'b1, 4'hF, 7'h30, 1'b0};
    vecs[5]  = '{11,  2'd1, 1'b0, 4'hF, 7'h30, 1'b0};
    vecs[6]  = '{12,  2'd1, 1'b0, 4'hD, 7'h41, 1'b0};
    vecs[7]  = '{20,  2'd2, 1'b1, 4'hF, 7'h41, 1'b0};
    vecs[8]  = '{22,  2'd2, 1'b0, 4'hB, 7'h12, 1'b0};
    vecs[9]  = '{32,  2'd3, 1'b0, 4'h7, 7'h23, 1'b0};
    vecs[10] = '{40,  2'd0, 1'b1, 4'hF, 7'h23, 1'b0};
    vecs[11] = '{42,  2'd0, 1'b0, 4'hE, 7'h78, 1'b0};
    vecs[12] = '{52,  2'd1, 1'b0, 4'hD, 7'h41, 1'b0};
    vecs[13] = '{62,  2'd2, 1'b0, 4'hB, 7'h12, 1'b0};
    vecs[14] = '{72,  2'd3, 1'b0, 4'h7, 7'h23, 1'b0};
    vecs[15] = '{80,  2'd0, 1'b1, 4'hF, 7'h23, 1'b0};
    vecs[16] = '{82,  2'd0, 1'b0, 4'hE, 7'h7F, 1'b1};
    vecs[17] = '{92,  2'd1, 1'b0, 4'hD, 7'h41, 1'b1};
    vecs[18] = '{102, 2'd2, 1'b0, 4'hB, 7'h12, 1'b1};
    codes = '{4'h3, 4'hA, 4'h5, 4'hB, 4'h7, 4'hA, 4'h5, 4'hB, 4'hE, 4'hA, 4'h5};

    Reset      = 1'b0;
    bus.Enable = 1'b1;
    bus.Code   = codes[0];
    repeat (2) step();
    chk_all("in_reset", 2'd0, 1'b0, 4'hF, 7'h7F, 1'b0);

    // Cycle n is the state after the n-th rising edge following release
    Reset = 1'b1;
    ticks = 0;
    for (int n = 0; n <= 103; n++) begin
      if (n > 0) step();
      bus.Code = codes[n / 10];
      if (n >= 41 && n <= 80 && bus.Tick === 1'b1) ticks++;
      for (int v = 0; v < 19; v++)
        if (vecs[v].cyc == n)
          chk_all($sformatf("cyc%0d", n), vecs[v].ph, vecs[v].tk, vecs[v].an, vecs[v].sg, vecs[v].er);
    end
    chk("tick_count_41_80", 16'(ticks), 16'd4);

    // Pause scan for 5 edges during phase-2 SHOW (cnt holds at 3)
    bus.Enable = 1'b0;
    step();
    chk_all("dis104", 2'd2, 1'b0, 4'hF, 7'h12, 1'b1);
    repeat (4) step();
    chk_all("dis108", 2'd2, 1'b0, 4'hF, 7'h12, 1'b1);
    bus.Enable = 1'b1;
    step();
    chk_all("reen109", 2'd2, 1'b0, 4'hF, 7'h12, 1'b1);
    step();
    chk_all("reen110", 2'd2, 1'b0, 4'hB, 7'h12, 1'b1);
    repeat (4) step();
    chk_all("frozen114", 2'd2, 1'b0, 4'hB, 7'h12, 1'b1);
    bus.Code = 4'hB;
    step();
    chk_all("tc115", 2'd3, 1'b1, 4'hF, 7'h12, 1'b1);
    repeat (2) step();
    chk_all("show117", 2'd3, 1'b0, 4'h7, 7'h23, 1'b1);

    // Asynchronous reset between edges
    #2;
    Reset = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 1'b0, 4'hF, 7'h7F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
Sequential counterpart to the parking-lot display multiplexer.
- Generates the 2-bit phase select that the multiplexer consumes: {Clock, ClockMetade} equivalent; 00 = Vazios, 01 = 'V' label, 10 = Ocupados, 11 = 'O' label.
- Takes back the multiplexed 4-bit code, blanks between phases to prevent ghosting, decodes to active-low 7-segment patterns and drives one active-low anode per phase.
- Sits between the occupancy counters/mux and the board's 4-digit display.

Parameters:
DIV_WIDTH, 16, width of scan prescaler counter
DIV_MAX, 49999, prescaler terminal count; phase period = DIV_MAX+1 enabled cycles
BLANK_CYCLES, 2, anode-off cycles at start of each phase; legal range 1..DIV_MAX

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Enable  in  1  scan enable; 0 = display dark, scan frozen
Code  in  4  multiplexed code returned from the display mux for the current Phase
Phase  out  2  mux select {Clock, ClockMetade}; 00 Vazios, 01 V label, 10 Ocupados, 11 O label
Tick  out  1  one-cycle pulse, high in the first cycle of each new Phase
Seg  out  7  {g,f,e,d,c,b,a}, active-low
Anode  out  4  digit enables, active-low; Anode[i] lit only when Phase == i
Err  out  1  sticky: an out-of-range Code was captured

Behaviour:
Reset values (asynchronous, Reset=0):
- Phase=00, Tick=0, Seg=1111111, Anode=1111, Err=0.
- Prescaler cnt=0, blank counter bcnt=0, state=BLANK.

Prescaler:
- cnt increments on each Enable=1 cycle.
- At cnt==DIV_MAX: cnt<=0, Phase<=Phase+1 (wraps 11->00), Tick<=1 for one cycle, state<=BLANK, bcnt<=0, Anode<=1111.

FSM states:
- BLANK:
  - Anode=1111, Seg holds its previous value; bcnt increments each enabled cycle.
  - When bcnt==BLANK_CYCLES-1: capture Code, Seg<=decode(Code), Anode<=~(1<<Phase), state<=SHOW.
- SHOW:
  - Anode and Seg hold; Code changes are ignored.
  - Code is captured exactly once per phase.
  - Leaves only on prescaler terminal count or when Enable falls.

Decode (active-low gfedcba):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- 1010 ('V', rendered U) = 1000001
- 1011 ('o') = 0100011
- 1100-1111 = 1111111 (blank) and set Err<=1. Err clears only on reset.

Enable=0:
- Next edge: Anode<=1111, state<=BLANK, bcnt<=0, Tick<=0.
- cnt and Phase frozen.
- On re-enable: cnt resumes from its held value; the current phase restarts with a full BLANK_CYCLES blank.

Timing and boundaries:
- After reset release with Enable=1, phase-0 digit lights BLANK_CYCLES cycles later.
- Captured Code is the value present during the last BLANK cycle. This gives the mux BLANK_CYCLES-1 cycles of settling after the Phase change.
- Terminal count arriving while still in BLANK restarts BLANK for the new phase. Unreachable with legal parameters.
- Reset asserted mid-SHOW forces all outputs to reset values immediately, with no wait for Clock.

Test Plan:
(Bench uses DIV_MAX=9, BLANK_CYCLES=2.)
- Reset release, Enable=1, Code=0011 -> Anode=1111 for cycles 0-1; cycle 2 Anode=1110, Seg=0110000; Phase=00.
- Continue, Code=1010 from cycle 10 -> Tick=1 at cycle 10, Phase=01, Anode=1111 at cycles 10-11; cycle 12 Anode=1101, Seg=1000001.
- Run 40 cycles with Code alternating per phase (7, 1010, 5, 1011) -> Phase sequence 00,01,10,11,00; Anode 1110,1101,1011,0111; Seg 1111000,1000001,0010010,0100011; exactly 4 Tick pulses.
- Code=1110 during phase-0 capture -> Seg=1111111, Err=1; Err stays 1 through later valid codes until Reset=0.
- Enable=0 for 5 cycles mid-SHOW of phase 10 -> Anode=1111 next cycle, Phase and cnt frozen; re-enable -> 2 blank cycles, then Anode=1011.
- Reset=0 asserted between clock edges during SHOW -> Anode=1111, Seg=1111111, Phase=00, Err=0 without a clock edge.
